sprite_blitter: RTL

- Upstream writer for the palette-indexed frame buffer: accepts one draw command at a time and copies a W x H sprite from sprite ROM to a destination (x,y) in the frame buffer.
- Transparent pixels are skipped; off-screen pixels are clipped.
- Throughput is 1 pixel/clock.
- Sits between game logic (command source) and the frame buffer write port; the frame buffer read port stays with the VGA side.

---
 rtl/sprite_blitter_pkg.sv | 28 ++
 rtl/sprite_blitter_if.sv | 33 +++
 rtl/sprite_blitter_coord_gen.sv | 63 ++++++
 rtl/sprite_blitter.sv | 111 +++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared constants and command/state types for the sprite blitter.
// Build option: SPRITE_BLIT_HFLIP_EN adds a per-command horizontal mirror flag.
package blit_pkg;

    localparam int FB_WIDTH  = 208;
    localparam int FB_HEIGHT = 84;
    localparam int FB_AW     = 15;
    localparam int SRC_AW    = 16;
    localparam int COLOR_W   = 5;
    localparam int DIM_W     = 7;
    localparam int POS_W     = 10;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 5'd0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} blit_state_t;

    typedef struct packed {
`ifdef SPRITE_BLIT_HFLIP_EN
        logic              hflip;
`endif
        logic [SRC_AW-1:0] base;
        logic [DIM_W-1:0]  w;
        logic [DIM_W-1:0]  h;
        logic [POS_W-1:0]  x;
        logic [POS_W-1:0]  y;
    } blit_cmd_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Draw-command handshake between game logic (master) and the blitter (slave).
// Build option: SPRITE_BLIT_HFLIP_EN adds cmd_hflip.
interface sprite_blitter_if;
    import blit_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SRC_AW-1:0] cmd_base;
    logic [DIM_W-1:0]  cmd_w;
    logic [DIM_W-1:0]  cmd_h;
    logic [POS_W-1:0]  cmd_x;
    logic [POS_W-1:0]  cmd_y;
`ifdef SPRITE_BLIT_HFLIP_EN
    logic              cmd_hflip;
`endif

    modport master (
`ifdef SPRITE_BLIT_HFLIP_EN
        output cmd_hflip,
`endif
        output cmd_valid, cmd_base, cmd_w, cmd_h, cmd_x, cmd_y,
        input  cmd_ready
    );

    modport slave (
`ifdef SPRITE_BLIT_HFLIP_EN
        input  cmd_hflip,
`endif
        input  cmd_valid, cmd_base, cmd_w, cmd_h, cmd_x, cmd_y,
        output cmd_ready
    );

endinterface

// File: rtl/sprite_blitter_coord_gen.sv
// Row-major sx/sy walker: source offset, destination dx/dy, clip flag, last flag.
// Build option: SPRITE_BLIT_HFLIP_EN mirrors the source column.
module blit_coord_gen
    import blit_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    step,
    input  logic [DIM_W-1:0]        w,
    input  logic [DIM_W-1:0]        h,
    input  logic [POS_W-1:0]        x,
    input  logic [POS_W-1:0]        y,
`ifdef SPRITE_BLIT_HFLIP_EN
    input  logic                    hflip,
`endif
    output logic [SRC_AW-1:0]       src_off,
    output logic signed [POS_W:0]   dx,
    output logic signed [POS_W:0]   dy,
    output logic                    in_bounds,
    output logic                    last
);

    logic [DIM_W-1:0]  sx, sy, col;
    logic [SRC_AW-1:0] row_base;
    logic              row_end;

    assign row_end = (sx == w - 7'd1);
    assign last    = row_end && (sy == h - 7'd1);

    // Row base accumulates w per row so no multiplier sits in the address path.
    always_ff @(posedge Clk) begin
        if (Reset || start) begin
            sx       <= '0;
            sy       <= '0;
            row_base <= '0;
        end else if (step) begin
            if (row_end) begin
                sx       <= '0;
                sy       <= sy + 7'd1;
                row_base <= row_base + SRC_AW'(w);
            end else begin
                sx <= sx + 7'd1;
            end
        end
    end

`ifdef SPRITE_BLIT_HFLIP_EN
    assign col = hflip ? (w - 7'd1 - sx) : sx;
`else
    assign col = sx;
`endif

    assign src_off = row_base + SRC_AW'(col);

    // One extra bit of headroom so a sprite crossing an edge never wraps back on screen.
    assign dx = $signed({x[POS_W-1], x}) + $signed({4'b0, sx});
    assign dy = $signed({y[POS_W-1], y}) + $signed({4'b0, sy});

    assign in_bounds = !dx[POS_W] && (dx[POS_W-1:0] < 10'(FB_WIDTH)) &&
                       !dy[POS_W] && (dy[POS_W-1:0] < 10'(FB_HEIGHT));

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a W x H ROM sprite into the frame buffer at 1 pixel/clock.
// Build option: SPRITE_BLIT_HFLIP_EN enables horizontally mirrored draws.
module sprite_blitter
    import blit_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    sprite_blitter_if.slave    cmd,
    output logic [SRC_AW-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_write_address,
    output logic [COLOR_W-1:0] fb_data_In,
    output logic               busy,
    output logic               done
);

    blit_state_t              state, state_nxt;
    blit_cmd_t                cmd_q;
    logic                     drain_cnt;
    logic                     accept;
    logic [SRC_AW-1:0]        src_off, rom_addr_run, rom_addr_q;
    logic signed [POS_W:0]    dx, dy;
    logic                     in_bounds, last;
    logic [1:0]               vld_pipe;
    logic                     p1_inb;
    logic [FB_AW-1:0]         p1_addr;
    logic                     wr_ok;

    // done is registered off FINISH, so busy stays up through the done cycle.
    assign busy          = (state != IDLE) || done;
    assign cmd.cmd_ready = !busy;
    assign accept        = cmd.cmd_valid && !busy;

    blit_coord_gen u_coord (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (accept),
        .step      (state == RUN),
        .w         (cmd_q.w),
        .h         (cmd_q.h),
        .x         (cmd_q.x),
        .y         (cmd_q.y),
`ifdef SPRITE_BLIT_HFLIP_EN
        .hflip     (cmd_q.hflip),
`endif
        .src_off   (src_off),
        .dx        (dx),
        .dy        (dy),
        .in_bounds (in_bounds),
        .last      (last)
    );

    assign rom_addr_run = cmd_q.base + src_off;
    assign rom_addr     = (state == RUN) ? rom_addr_run : rom_addr_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)
                         state_nxt = (cmd.cmd_w == '0 || cmd.cmd_h == '0) ? FINISH : RUN;
            RUN:     if (last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_ok = vld_pipe[0] && p1_inb && (rom_data != TRANSPARENT);
    assign fb_we = vld_pipe[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            drain_cnt        <= 1'b0;
            done             <= 1'b0;
            cmd_q            <= '0;
            rom_addr_q       <= '0;
            vld_pipe         <= '0;
            p1_inb           <= 1'b0;
            p1_addr          <= '0;
            fb_write_address <= '0;
            fb_data_In       <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            done      <= (state == FINISH);
            if (accept) begin
                cmd_q.base <= cmd.cmd_base;
                cmd_q.w    <= cmd.cmd_w;
                cmd_q.h    <= cmd.cmd_h;
                cmd_q.x    <= cmd.cmd_x;
                cmd_q.y    <= cmd.cmd_y;
`ifdef SPRITE_BLIT_HFLIP_EN
                cmd_q.hflip <= cmd.cmd_hflip;
`endif
            end
            if (state == RUN) rom_addr_q <= rom_addr_run;
            // Clip flag and address travel one stage alongside the ROM read.
            vld_pipe <= {wr_ok, state == RUN};
            p1_inb   <= in_bounds;
            if (in_bounds)
                p1_addr <= FB_AW'(dy) * FB_AW'(FB_WIDTH) + FB_AW'(dx);
            if (wr_ok) begin
                fb_write_address <= p1_addr;
                fb_data_In       <= rom_data;
            end
        end
    end

endmodule
